// File: rtl/esc_pkg.sv
// Shared types and LP line-state constants for the escape-mode LP encoder.
package esc_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ENT_10,
    ENT_00A,
    ENT_01,
    ENT_00B,
    MARK,
    SPACE,
    EXIT_MARK,
    STOP
  } esc_state_t;

  localparam logic [1:0] LP_STOP  = 2'b11;
  localparam logic [1:0] LP_MARK1 = 2'b10;
  localparam logic [1:0] LP_MARK0 = 2'b01;
  localparam logic [1:0] LP_SPACE = 2'b00;

  function automatic esc_state_t next_entry(input esc_state_t s);
    case (s)
      ENT_10:  return ENT_00A;
      ENT_00A: return ENT_01;
      ENT_01:  return ENT_00B;
      default: return MARK;
    endcase
  endfunction

  function automatic logic [1:0] entry_lp(input esc_state_t s);
    case (s)
      ENT_10:  return LP_MARK1;
      ENT_01:  return LP_MARK0;
      default: return LP_SPACE;
    endcase
  endfunction

  function automatic logic [1:0] mark_lp(input logic b);
    return b ? LP_MARK1 : LP_MARK0;
  endfunction

endpackage

// File: rtl/esc_lp_encoder.sv
// Escape-mode LP encoder: entry sequence, spaced one-hot bit marks, exit.
// Optional ESC_FRAME_CHECK_EN adds FrameErr and a per-byte bit counter.
module esc_lp_encoder
  import esc_pkg::*;
#(
  parameter int LP_HOLD = 1
) (
  input  logic       TxClkEsc,
  input  logic       rst,
  input  logic       TxRequestEsc,
  input  logic       SerBit,
  input  logic       LastBit,
  output logic       EscSerEn,
  output logic [1:0] LpOut,
  output logic       EscBusy,
  output logic       TxDoneEsc
`ifdef ESC_FRAME_CHECK_EN
  ,
  output logic       FrameErr
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(LP_HOLD - 1);

  esc_state_t state;
  logic [3:0] hold;
  logic       last_q;
`ifdef ESC_FRAME_CHECK_EN
  logic [2:0] bit_cnt;
`endif

  always_ff @(posedge TxClkEsc or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold      <= '0;
      last_q    <= 1'b0;
      LpOut     <= LP_STOP;
      EscSerEn  <= 1'b0;
      EscBusy   <= 1'b0;
      TxDoneEsc <= 1'b0;
`ifdef ESC_FRAME_CHECK_EN
      bit_cnt   <= '0;
      FrameErr  <= 1'b0;
`endif
    end else begin
      EscSerEn  <= 1'b0;
      TxDoneEsc <= 1'b0;
`ifdef ESC_FRAME_CHECK_EN
      FrameErr  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (TxRequestEsc) begin
            state   <= ENT_10;
            LpOut   <= LP_MARK1;
            EscBusy <= 1'b1;
            hold    <= '0;
          end
        end
        ENT_10, ENT_00A, ENT_01, ENT_00B: begin
          if (!TxRequestEsc) begin
            // Aborted entry: back to stop without a done pulse
            state <= STOP;
            LpOut <= LP_STOP;
            hold  <= '0;
          end else if (hold != HOLD_LAST) begin
            hold     <= hold + 4'd1;
            EscSerEn <= (state == ENT_00B)
                     && (hold + 4'd1 == HOLD_LAST);
          end else if (state == ENT_00B) begin
            hold   <= '0;
            state  <= MARK;
            LpOut  <= mark_lp(SerBit);
            last_q <= LastBit;
`ifdef ESC_FRAME_CHECK_EN
            bit_cnt <= '0;
`endif
          end else begin
            hold     <= '0;
            state    <= next_entry(state);
            LpOut    <= entry_lp(next_entry(state));
            EscSerEn <= (state == ENT_01)
                     && (HOLD_LAST == 4'd0);
          end
        end
        MARK: begin
          state    <= SPACE;
          LpOut    <= LP_SPACE;
          EscSerEn <= 1'b1;
`ifdef ESC_FRAME_CHECK_EN
          FrameErr <= last_q != (bit_cnt == 3'd7);
`endif
        end
        SPACE: begin
          // Request drop only takes effect at a byte boundary
          if (!last_q || TxRequestEsc) begin
            state  <= MARK;
            LpOut  <= mark_lp(SerBit);
            last_q <= LastBit;
`ifdef ESC_FRAME_CHECK_EN
            bit_cnt <= bit_cnt + 3'd1;
`endif
          end else begin
            state <= EXIT_MARK;
            LpOut <= LP_MARK1;
          end
        end
        EXIT_MARK: begin
          state     <= STOP;
          LpOut     <= LP_STOP;
          TxDoneEsc <= 1'b1;
        end
        STOP: begin
          state   <= IDLE;
          LpOut   <= LP_STOP;
          EscBusy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          LpOut   <= LP_STOP;
          EscBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
